// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared widths and state encoding for the ATM FSM and account server
package atm_pkg;

  localparam int DEF_BALANCE_WIDTH = 20;
  localparam int DEF_ID_W          = 2;
  localparam int DEF_PIN_W         = 16;

  localparam logic [1:0] FAIL_MAX = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_WAIT_PIN = 3'd2,
    ST_CHECK    = 3'd3,
    ST_SESSION  = 3'd4
  } state_t;

endpackage

// File: rtl/atm_account_table.sv
// rtl/atm_account_table.sv - account balances, PINs, fail counters (locks with ATM_SERVER_LOCKOUT_EN)
module atm_account_table
  import atm_pkg::*;
#(
  parameter int                      BALANCE_WIDTH = DEF_BALANCE_WIDTH,
  parameter int                      ID_W          = DEF_ID_W,
  parameter int                      PIN_W         = DEF_PIN_W,
  parameter logic [BALANCE_WIDTH-1:0] INIT_BALANCE = BALANCE_WIDTH'(1000),
  parameter logic [PIN_W-1:0]        DEFAULT_PIN   = PIN_W'(16'h1234)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          id,
  output logic [BALANCE_WIDTH-1:0] balance,
  output logic [PIN_W-1:0]         pin,
`ifdef ATM_SERVER_LOCKOUT_EN
  output logic [1:0]               fail_count,
  output logic                     locked,
`endif
  input  logic                     prog_en,
  input  logic [ID_W-1:0]          prog_id,
  input  logic [PIN_W-1:0]         prog_pin,
  input  logic [BALANCE_WIDTH-1:0] prog_balance,
  input  logic                     wb_en,
  input  logic [BALANCE_WIDTH-1:0] wb_balance,
  input  logic                     fail_clr,
  input  logic                     fail_inc
);

  localparam int NUM_ACCOUNTS = 2 ** ID_W;

  logic [BALANCE_WIDTH-1:0] bal_mem  [NUM_ACCOUNTS];
  logic [PIN_W-1:0]         pin_mem  [NUM_ACCOUNTS];
  logic [1:0]               fail_cnt [NUM_ACCOUNTS];

  assign balance = bal_mem[id];
  assign pin     = pin_mem[id];

  // Provisioning only happens in IDLE and writeback only in SESSION, so the
  // two write sources never collide; prog_en is still given priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_mem[i]  <= INIT_BALANCE;
        pin_mem[i]  <= DEFAULT_PIN;
        fail_cnt[i] <= 2'd0;
      end
    end else begin
      if (prog_en) begin
        bal_mem[prog_id]  <= prog_balance;
        pin_mem[prog_id]  <= prog_pin;
        fail_cnt[prog_id] <= 2'd0;
      end else if (wb_en) begin
        bal_mem[id] <= wb_balance;
      end
      if (fail_clr) begin
        fail_cnt[id] <= 2'd0;
      end else if (fail_inc && (fail_cnt[id] != FAIL_MAX)) begin
        fail_cnt[id] <= fail_cnt[id] + 2'd1;
      end
    end
  end

`ifdef ATM_SERVER_LOCKOUT_EN
  logic [NUM_ACCOUNTS-1:0] lock_mem;

  assign fail_count = fail_cnt[id];
  assign locked     = lock_mem[id];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_mem <= '0;
    end else begin
      if (prog_en) begin
        lock_mem[prog_id] <= 1'b0;
      end
      if (fail_inc && (fail_cnt[id] >= FAIL_MAX - 2'd1)) begin
        lock_mem[id] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/atm_account_server.sv
// rtl/atm_account_server.sv - bank-side account/PIN responder for the ATM; lockout via ATM_SERVER_LOCKOUT_EN
module atm_account_server
  import atm_pkg::*;
#(
  parameter int                      BALANCE_WIDTH = DEF_BALANCE_WIDTH,
  parameter int                      ID_W          = DEF_ID_W,
  parameter int                      PIN_W         = DEF_PIN_W,
  parameter logic [BALANCE_WIDTH-1:0] INIT_BALANCE = BALANCE_WIDTH'(1000),
  parameter logic [PIN_W-1:0]        DEFAULT_PIN   = PIN_W'(16'h1234)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_valid,
  input  logic [ID_W-1:0]          card_id,
  input  logic                     pin_valid,
  input  logic [PIN_W-1:0]         pin,
  input  logic                     wb_valid,
  input  logic [BALANCE_WIDTH-1:0] wb_balance,
  input  logic                     session_end,
  input  logic                     prog_en,
  input  logic [ID_W-1:0]          prog_id,
  input  logic [PIN_W-1:0]         prog_pin,
  input  logic [BALANCE_WIDTH-1:0] prog_balance,
  output logic [BALANCE_WIDTH-1:0] current_balance,
  output logic                     auth_done,
  output logic                     wrong_psw,
  output logic                     wb_ack,
  output logic                     busy,
  output logic                     locked
);

  state_t state, next_state;

  logic [ID_W-1:0]          id_q, id_d;
  logic [PIN_W-1:0]         pin_q, pin_d;
  logic [BALANCE_WIDTH-1:0] balance_d;
  logic                     auth_d, wrong_d, ack_d, locked_d;

  logic [BALANCE_WIDTH-1:0] tbl_balance;
  logic [PIN_W-1:0]         tbl_pin;
  logic                     tbl_prog, tbl_wb, fail_clr, fail_inc;
`ifdef ATM_SERVER_LOCKOUT_EN
  logic [1:0]               tbl_fail_cnt;
  logic                     tbl_locked;
`endif

  atm_account_table #(
    .BALANCE_WIDTH (BALANCE_WIDTH),
    .ID_W          (ID_W),
    .PIN_W         (PIN_W),
    .INIT_BALANCE  (INIT_BALANCE),
    .DEFAULT_PIN   (DEFAULT_PIN)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .id           (id_q),
    .balance      (tbl_balance),
    .pin          (tbl_pin),
`ifdef ATM_SERVER_LOCKOUT_EN
    .fail_count   (tbl_fail_cnt),
    .locked       (tbl_locked),
`endif
    .prog_en      (tbl_prog),
    .prog_id      (prog_id),
    .prog_pin     (prog_pin),
    .prog_balance (prog_balance),
    .wb_en        (tbl_wb),
    .wb_balance   (wb_balance),
    .fail_clr     (fail_clr),
    .fail_inc     (fail_inc)
  );

  always_comb begin
    next_state = state;
    id_d       = id_q;
    pin_d      = pin_q;
    balance_d  = current_balance;
    auth_d     = 1'b0;
    wrong_d    = 1'b0;
    ack_d      = 1'b0;
    locked_d   = 1'b0;
    tbl_prog   = 1'b0;
    tbl_wb     = 1'b0;
    fail_clr   = 1'b0;
    fail_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        tbl_prog = prog_en;
        if (card_valid) begin
          id_d       = card_id;
          next_state = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (session_end) begin
          next_state = ST_IDLE;
          balance_d  = '0;
        end else begin
          balance_d  = tbl_balance;
          next_state = ST_WAIT_PIN;
`ifdef ATM_SERVER_LOCKOUT_EN
          if (tbl_locked) begin
            balance_d  = '0;
            auth_d     = 1'b1;
            wrong_d    = 1'b1;
            locked_d   = 1'b1;
            next_state = ST_IDLE;
          end
`endif
        end
      end
      ST_WAIT_PIN: begin
        if (session_end) begin
          next_state = ST_IDLE;
          balance_d  = '0;
        end else if (pin_valid) begin
          pin_d      = pin;
          next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (session_end) begin
          next_state = ST_IDLE;
          balance_d  = '0;
        end else if (pin_q == tbl_pin) begin
          auth_d     = 1'b1;
          fail_clr   = 1'b1;
          next_state = ST_SESSION;
        end else begin
          auth_d     = 1'b1;
          wrong_d    = 1'b1;
          fail_inc   = 1'b1;
          next_state = ST_WAIT_PIN;
`ifdef ATM_SERVER_LOCKOUT_EN
          if (tbl_fail_cnt >= FAIL_MAX - 2'd1) begin
            locked_d   = 1'b1;
            balance_d  = '0;
            next_state = ST_IDLE;
          end
`endif
        end
      end
      ST_SESSION: begin
        if (wb_valid) begin
          tbl_wb    = 1'b1;
          balance_d = wb_balance;
          ack_d     = 1'b1;
        end
        // Ending the session clears the visible balance even if a writeback commits.
        if (session_end) begin
          next_state = ST_IDLE;
          balance_d  = '0;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      id_q            <= '0;
      pin_q           <= '0;
      current_balance <= '0;
      auth_done       <= 1'b0;
      wrong_psw       <= 1'b0;
      wb_ack          <= 1'b0;
      busy            <= 1'b0;
      locked          <= 1'b0;
    end else begin
      state           <= next_state;
      id_q            <= id_d;
      pin_q           <= pin_d;
      current_balance <= balance_d;
      auth_done       <= auth_d;
      wrong_psw       <= wrong_d;
      wb_ack          <= ack_d;
      busy            <= (next_state != ST_IDLE);
      locked          <= locked_d;
    end
  end

endmodule

// File: tb/tb_atm_account_server.sv
// tb/tb_atm_account_server.sv - directed vector bench for atm_account_server
module tb_atm_account_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_valid;
  logic [1:0]  card_id;
  logic        pin_valid;
  logic [15:0] pin;
  logic        wb_valid;
  logic [19:0] wb_balance;
  logic        session_end;
  logic        prog_en;
  logic [1:0]  prog_id;
  logic [15:0] prog_pin;
  logic [19:0] prog_balance;
  logic [19:0] current_balance;
  logic        auth_done, wrong_psw, wb_ack, busy, locked;

  int total = 0;
  int bad   = 0;

  atm_account_server dut (
    .clk             (clk),
    .rst             (rst),
    .card_valid      (card_valid),
    .card_id         (card_id),
    .pin_valid       (pin_valid),
    .pin             (pin),
    .wb_valid        (wb_valid),
    .wb_balance      (wb_balance),
    .session_end     (session_end),
    .prog_en         (prog_en),
    .prog_id         (prog_id),
    .prog_pin        (prog_pin),
    .prog_balance    (prog_balance),
    .current_balance (current_balance),
    .auth_done       (auth_done),
    .wrong_psw       (wrong_psw),
    .wb_ack          (wb_ack),
    .busy            (busy),
    .locked          (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [1:0]  cid;
    logic        pv;
    logic [15:0] pin;
    logic        wv;
    logic [19:0] wb;
    logic        se;
    logic        pe;
    logic [1:0]  pid;
    logic [15:0] ppin;
    logic [19:0] pbal;
    logic        busy;
    logic        auth;
    logic        wrong;
    logic        ack;
    logic [19:0] bal;
    logic        chk_bal;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    card_valid = 0; card_id = 0; pin_valid = 0; pin = 0; wb_valid = 0; wb_balance = 0;
    session_end = 0; prog_en = 0; prog_id = 0; prog_pin = 0; prog_balance = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic add(input logic cv, input logic [1:0] cid, input logic pv, input logic [15:0] p,
                     input logic wv, input logic [19:0] wb, input logic se,
                     input logic pe, input logic [1:0] pid, input logic [15:0] ppin, input logic [19:0] pbal,
                     input logic eb, input logic ea, input logic ew, input logic ek,
                     input logic [19:0] ebal, input logic cb);
    vec_t v;
    v.cv = cv; v.cid = cid; v.pv = pv; v.pin = p; v.wv = wv; v.wb = wb; v.se = se;
    v.pe = pe; v.pid = pid; v.ppin = ppin; v.pbal = pbal;
    v.busy = eb; v.auth = ea; v.wrong = ew; v.ack = ek; v.bal = ebal; v.chk_bal = cb;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic eb, input logic ea, input logic ew,
                            input logic ek, input logic el, input logic [19:0] ebal, input logic cb);
    check({tag, "_busy"},  32'(busy),      32'(eb));
    check({tag, "_auth"},  32'(auth_done), 32'(ea));
    if (ea) check({tag, "_wrong"}, 32'(wrong_psw), 32'(ew));
    check({tag, "_ack"},   32'(wb_ack),    32'(ek));
    check({tag, "_lock"},  32'(locked),    32'(el));
    if (cb) check({tag, "_bal"}, 32'(current_balance), 32'(ebal));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 20'd0, 1);
    rst = 1'b1;

    //   cv cid pv pin       wv wb       se  pe pid ppin     pbal      busy au wr ak bal        chk
    add(1, 2, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd0,    1); // 0 LOOKUP
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd1000, 1); // 1 balance out
    add(0, 0, 1, 16'h1234, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd1000, 1); // 2 pin in
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 1, 0, 0, 20'd1000, 1); // 3 auth ok
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd1000, 1); // 4
    add(0, 0, 0, 16'h0000, 1, 20'd700, 0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 1, 20'd700,  1); // 5 writeback
    add(0, 0, 0, 16'h0000, 0, 20'd0,   1,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 6 end
    add(1, 2, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd0,    1); // 7
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd700,  1); // 8 reads 700
    add(0, 0, 1, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd700,  1); // 9 bad pin
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 1, 1, 0, 20'd700,  1); // 10 wrong
    add(0, 0, 1, 16'h1234, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd700,  1); // 11 retry
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 1, 0, 0, 20'd700,  1); // 12 ok
    add(0, 0, 0, 16'h0000, 1, 20'd50,  1,  0, 0, 16'h0, 20'd0,   0, 0, 0, 1, 20'd0,    0); // 13 wb+end
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 14
    add(1, 2, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd0,    1); // 15
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd50,   1); // 16 reads 50
    add(0, 0, 0, 16'h0000, 0, 20'd0,   1,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 17 end in WAIT_PIN
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 18
    add(1, 1, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd0,    1); // 19 id 1
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd1000, 1); // 20
    add(0, 0, 1, 16'h1234, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd1000, 1); // 21
    add(0, 0, 0, 16'h0000, 0, 20'd0,   1,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 22 end in CHECK
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 23 no auth
    add(0, 0, 0, 16'h0000, 1, 20'd999, 0,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 24 wb in IDLE
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 25
    add(1, 3, 0, 16'h0000, 0, 20'd0,   0,  1, 3, 16'hBEEF, 20'd5, 1, 0, 0, 0, 20'd0,   1); // 26 prog+card
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  1, 0, 16'h0, 20'd77,  1, 0, 0, 0, 20'd5,    1); // 27 reads 5
    add(0, 0, 1, 16'hBEEF, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd5,    1); // 28
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 1, 0, 0, 20'd5,    1); // 29 BEEF ok
    add(0, 0, 0, 16'h0000, 0, 20'd0,   1,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 30
    add(1, 1, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd0,    1); // 31
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  1, 1, 16'h0, 20'd7,   1, 0, 0, 0, 20'd1000, 1); // 32 999 not stored
    add(0, 0, 0, 16'h0000, 0, 20'd0,   1,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 33
    add(1, 1, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd0,    1); // 34
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   1, 0, 0, 0, 20'd1000, 1); // 35 prog ignored
    add(1, 0, 0, 16'h0000, 0, 20'd0,   1,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 36 end; card ignored
    add(0, 0, 0, 16'h0000, 0, 20'd0,   0,  0, 0, 16'h0, 20'd0,   0, 0, 0, 0, 20'd0,    1); // 37

    for (int i = 0; i < vecs.size(); i++) begin
      card_valid = vecs[i].cv; card_id = vecs[i].cid; pin_valid = vecs[i].pv; pin = vecs[i].pin;
      wb_valid = vecs[i].wv; wb_balance = vecs[i].wb; session_end = vecs[i].se;
      prog_en = vecs[i].pe; prog_id = vecs[i].pid; prog_pin = vecs[i].ppin; prog_balance = vecs[i].pbal;
      cyc();
      check_outs($sformatf("v%0d", i), vecs[i].busy, vecs[i].auth, vecs[i].wrong, vecs[i].ack,
                 1'b0, vecs[i].bal, vecs[i].chk_bal);
    end

    // Fail counter increments on a mismatch and clears on the next match.
    card_valid = 1; card_id = 0; cyc();
    cyc();
    check_outs("fc_bal", 1, 0, 0, 0, 0, 20'd1000, 1);
    pin_valid = 1; pin = 16'h1111; cyc();
    cyc();
    check_outs("fc_wrong", 1, 1, 1, 0, 0, 20'd1000, 1);
    check("fc_cnt1", 32'(dut.u_table.fail_cnt[0]), 32'd1);
    pin_valid = 1; pin = 16'h1234; cyc();
    cyc();
    check_outs("fc_ok", 1, 1, 0, 0, 0, 20'd1000, 1);
    check("fc_cnt0", 32'(dut.u_table.fail_cnt[0]), 32'd0);
    session_end = 1; cyc();
    check_outs("fc_end", 0, 0, 0, 0, 0, 20'd0, 1);

    card_valid = 1; card_id = 0; cyc();
    cyc();
`ifdef ATM_SERVER_LOCKOUT_EN
    for (int k = 0; k < 3; k++) begin
      pin_valid = 1; pin = 16'h0000; cyc();
      cyc();
      if (k < 2) check_outs($sformatf("lk_strike%0d", k), 1, 1, 1, 0, 0, 20'd1000, 1);
      else       check_outs("lk_strike2", 0, 1, 1, 0, 1, 20'd0, 1);
    end
    cyc();
    check_outs("lk_after", 0, 0, 0, 0, 0, 20'd0, 1);
    card_valid = 1; card_id = 0; cyc();
    check_outs("lk_reins0", 1, 0, 0, 0, 0, 20'd0, 1);
    cyc();
    check_outs("lk_reins1", 0, 1, 1, 0, 1, 20'd0, 1);
    prog_en = 1; prog_id = 0; prog_pin = 16'h1234; prog_balance = 20'd42;
    card_valid = 1; card_id = 0; cyc();
    cyc();
    check_outs("lk_unlock", 1, 0, 0, 0, 0, 20'd42, 1);
    session_end = 1; cyc();
`else
    for (int k = 0; k < 3; k++) begin
      pin_valid = 1; pin = 16'h0000; cyc();
      cyc();
      check_outs($sformatf("nl_strike%0d", k), 1, 1, 1, 0, 0, 20'd1000, 1);
    end
    check("nl_cnt_sat", 32'(dut.u_table.fail_cnt[0]), 32'd3);
    session_end = 1; cyc();
    check_outs("nl_end", 0, 0, 0, 0, 0, 20'd0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
